mmap_loader: RTL and testbench
==============================

// Module: mmap_loader
// PURPOSE
// Upstream stage of the mmap block. Accepts a job descriptor (base address, word count).
// Writes a valid/ready stream of data words into the shared dual_port_memory at base..base+len-1.
// Then writes the start word to the control address, which kicks mmap.
// Owns memory port B while o_busy=1. The top-level mux hands port B to mmap otherwise.
// PARAMETERS
// DATA_WIDTH  32     memory word width
// ADDR_WIDTH  10     memory address width
// FIFO_DEPTH  2      input buffer entries, power of 2, >=2
// CTRL_ADDR   0      address of the mmap control word
// START_WORD  32'h1  value written to CTRL_ADDR; bit0 is the mmap start bit
// PORTS
// i_clk        in   1           clock; all logic on the rising edge
// i_rst        in   1           synchronous reset, active-high
// i_cfg_valid  in   1           descriptor valid
// o_cfg_ready  out  1           descriptor accepted when valid&&ready
// i_cfg_base   in   ADDR_WIDTH  first data address
// i_cfg_len    in   ADDR_WIDTH  number of data words
// i_s_valid    in   1           stream word valid
// o_s_ready    out  1           stream word accepted when valid&&ready
// i_s_data     in   DATA_WIDTH  stream word
// o_addr       out  ADDR_WIDTH  memory write address (to port B)
// o_we         out  1           write strobe; top expands it to 4'b1111
// o_data       out  DATA_WIDTH  memory write data
// o_busy       out  1           1 from descriptor accept until the o_done cycle, inclusive
// o_done       out  1           one-cycle pulse; the start word was written the previous cycle
// o_err        out  1           one-cycle pulse; descriptor rejected
// BEHAVIOUR
// - Reset: all outputs 0 except o_cfg_ready=1 (state IDLE); FIFO empty; counters 0.
// - All outputs are registered.
// - Reset mid-job: aborts immediately, FIFO is flushed, and the start word is never written.
// - FSM: IDLE -> LOAD -> START -> DONE -> IDLE.
// - IDLE: o_cfg_ready=1. On handshake, base and len are checked in ADDR_WIDTH+1-bit arithmetic:
//   - Reject if len==0, or base+len > 2**ADDR_WIDTH (no wrap allowed),
//     or base <= CTRL_ADDR <= base+len-1.
//   - Reject: o_err=1 next cycle, stay IDLE, no writes.
//   - Accept: latch base and len, go to LOAD, o_busy=1.
// - LOAD:
//   - o_s_ready = (accepted_cnt < len) && !fifo_full. The block never over-accepts.
//   - Each cycle the FIFO is non-empty: pop one word and drive o_we=1, o_addr=base+wr_cnt, o_data=word.
//   - A word accepted in cycle N is written no earlier than cycle N+1 (N+1 when the FIFO was empty).
//   - Simultaneous push and pop are allowed; occupancy is unchanged.
//   - Words are written in arrival order. o_we=0 in cycles where the FIFO is empty.
// - LOAD->START: the cycle after the write with wr_cnt==len-1.
// - START: one cycle with o_we=1, o_addr=CTRL_ADDR, o_data=START_WORD.
// - DONE: o_done=1 for one cycle, o_busy drops after it, then IDLE.
// - Per job o_we is high exactly len+1 cycles. Data addresses never equal CTRL_ADDR.
// - o_cfg_ready=0 and descriptors are ignored outside IDLE.
// - o_s_ready=0 outside LOAD. Stream words offered outside LOAD are not consumed.
// CONFIGURATION
// - LOADER_CHECKSUM_EN defined: adds port o_checksum (out, DATA_WIDTH).
//   - Value is the sum mod 2**DATA_WIDTH of all data words written in the current job.
//   - Cleared to 0 on descriptor accept and on reset.
//   - Final value is stable from the o_done cycle until the next accept.
// - LOADER_CHECKSUM_EN undefined: port and adder are absent; behaviour is otherwise identical.
// TESTING
// - Load: base=1, len=7, data i*16000 (i=1..7), i_s_valid held 1.
//   -> mem[1..7]=16000..112000, then mem[0]=32'h1, one o_done pulse, o_we high 8 cycles.
// - Backpressure: same job with i_s_valid toggled every other cycle.
//   -> identical memory image, writes in order, no gaps wrongly written.
// - Reject: base=0 len=4 -> o_err pulse. len=0 -> o_err. base=1021 len=4 -> o_err.
//   In all three cases there is no o_we and the FSM returns to IDLE.
// - Edge: base=1020 len=4 -> mem[1020..1023] written, then mem[0]=1.
//   Also: 9 words offered for len=8 -> 9th word not accepted.
// - Reset mid-job: assert i_rst after 3 of 7 words are written.
//   -> no further o_we, mem[0] unchanged, outputs at reset values, next job runs normally.
// - LOADER_CHECKSUM_EN: words 1,2,32'hFFFFFFFF -> o_checksum=32'h2 at o_done.
//   Next accept clears o_checksum to 0.

Source files
------------

// File: rtl/mmap_loader.sv
// mmap_loader: loads a descriptor-sized burst of stream words into memory
// port B, then writes START_WORD to CTRL_ADDR to kick the mmap block.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_cfg_valid/o_cfg_ready  descriptor handshake (i_cfg_base, i_cfg_len)
//   i_s_valid/o_s_ready      data stream handshake (i_s_data)
//   o_addr, o_we, o_data     registered memory write port
//   o_busy, o_done, o_err    job status (o_done/o_err are one-cycle pulses)
//   o_checksum               sum of the job's data words, present only
//                            when LOADER_CHECKSUM_EN is defined
module mmap_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 2,
    parameter int CTRL_ADDR  = 0,
    parameter logic [DATA_WIDTH-1:0] START_WORD = 32'h1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic [ADDR_WIDTH-1:0] i_cfg_base,
    input  logic [ADDR_WIDTH-1:0] i_cfg_len,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_we,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] o_checksum
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] CTRL_X = (ADDR_WIDTH+1)'(CTRL_ADDR);
    localparam logic [ADDR_WIDTH:0] SPACE  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW:0]         FULL   = (PW+1)'(FIFO_DEPTH);

    // The state names the phase currently visible on the registered outputs.
    typedef enum logic [1:0] {IDLE, LOAD, START, DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] base, len, len_nx;
    logic [ADDR_WIDTH:0]   acc_cnt, acc_nx;
    logic [ADDR_WIDTH:0]   wr_cnt, wr_nx;
    logic [ADDR_WIDTH:0]   end_x;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [PW:0]           fifo_cnt, cnt_nx;
    logic                  cfg_hs, cfg_ok, accept;
    logic                  push, pop, bypass, fifo_wr, have_word;
    logic [DATA_WIDTH-1:0] word;

    always_comb begin
        cfg_hs   = (state == IDLE) && i_cfg_valid && o_cfg_ready;
        // Extra bit so base+len cannot wrap and hide an overflow.
        end_x    = {1'b0, i_cfg_base} + {1'b0, i_cfg_len};
        cfg_ok   = (i_cfg_len != '0) && (end_x <= SPACE) &&
                   !(({1'b0, i_cfg_base} <= CTRL_X) && (CTRL_X < end_x));
        accept   = cfg_hs && cfg_ok;
        push     = (state == LOAD) && o_s_ready && i_s_valid;
        pop      = (state == LOAD) && (fifo_cnt != '0);
        // An empty buffer forwards the arriving word straight to the port.
        bypass   = push && (fifo_cnt == '0);
        fifo_wr  = push && !bypass;
        have_word = pop || bypass;
        word     = pop ? fifo_mem[rd_ptr] : i_s_data;
        cnt_nx   = fifo_cnt + (PW+1)'(fifo_wr) - (PW+1)'(pop);
        acc_nx   = acc_cnt + (ADDR_WIDTH+1)'(push);
        wr_nx    = wr_cnt + (ADDR_WIDTH+1)'(have_word);
        len_nx   = len;
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = LOAD;
                    acc_nx   = '0;
                    wr_nx    = '0;
                    len_nx   = i_cfg_len;
                end
            end
            LOAD: begin
                if (wr_cnt == {1'b0, len}) state_nx = START;
            end
            START: state_nx = DONE;
            DONE:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= i_s_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            base        <= '0;
            len         <= '0;
            acc_cnt     <= '0;
            wr_cnt      <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_cnt    <= '0;
            o_cfg_ready <= 1'b1;
            o_s_ready   <= 1'b0;
            o_addr      <= '0;
            o_we        <= 1'b0;
            o_data      <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state    <= state_nx;
            len      <= len_nx;
            acc_cnt  <= acc_nx;
            wr_cnt   <= wr_nx;
            fifo_cnt <= cnt_nx;
            if (accept) base <= i_cfg_base;
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
            o_cfg_ready <= (state_nx == IDLE);
            o_busy      <= (state_nx != IDLE);
            o_done      <= (state_nx == DONE);
            o_err       <= cfg_hs && !cfg_ok;
            o_s_ready   <= (state_nx == LOAD) &&
                           (acc_nx < {1'b0, len_nx}) && (cnt_nx != FULL);
            o_we        <= 1'b0;
            if (state_nx == START) begin
                o_we   <= 1'b1;
                o_addr <= CTRL_X[ADDR_WIDTH-1:0];
                o_data <= START_WORD;
            end else if (have_word) begin
                o_we   <= 1'b1;
                o_addr <= base + wr_cnt[ADDR_WIDTH-1:0];
                o_data <= word;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge i_clk) begin
        if (i_rst || accept) o_checksum <= '0;
        else if (have_word)  o_checksum <= o_checksum + word;
    end
`endif

endmodule

// File: tb/tb_mmap_loader.sv
// tb_mmap_loader: directed, table-driven bench for mmap_loader.
// Models memory port B and checks image, order, pulses and handshakes.
module tb_mmap_loader;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_cfg_valid = 1'b0;
    logic          o_cfg_ready;
    logic [AW-1:0] i_cfg_base = '0;
    logic [AW-1:0] i_cfg_len = '0;
    logic          i_s_valid = 1'b0;
    logic          o_s_ready;
    logic [DW-1:0] i_s_data = '0;
    logic [AW-1:0] o_addr;
    logic          o_we;
    logic [DW-1:0] o_data;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0] o_checksum;
`endif

    always #5 i_clk = ~i_clk;

    mmap_loader dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cfg_valid (i_cfg_valid),
        .o_cfg_ready (o_cfg_ready),
        .i_cfg_base  (i_cfg_base),
        .i_cfg_len   (i_cfg_len),
        .i_s_valid   (i_s_valid),
        .o_s_ready   (o_s_ready),
        .i_s_data    (i_s_data),
        .o_addr      (o_addr),
        .o_we        (o_we),
        .o_data      (o_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
`ifdef LOADER_CHECKSUM_EN
        ,
        .o_checksum  (o_checksum)
`endif
    );

    typedef struct {
        string name;
        int    base;
        int    len;
        int    nwords;
        bit    toggle;
        bit    exp_err;
        int    exp_acc;
        int    exp_we;
    } vec_t;

    int            errors = 0;
    int            checks = 0;
    int            we_cnt, done_cnt, err_cnt, bad_busy;
    logic [DW-1:0] img [1024];
    bit            written [1024];
    int            wq_addr [$];
    logic [DW-1:0] src [16];
    logic [DW-1:0] chk_at_done;
    logic [DW-1:0] chk_after_acc;
    vec_t          vecs [7];

    // Memory model of port B, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_we) begin
                img[o_addr] = o_data;
                written[o_addr] = 1'b1;
                we_cnt++;
                wq_addr.push_back(int'(o_addr));
            end
            if (o_done) begin
                done_cnt++;
                if (!o_busy) bad_busy++;
`ifdef LOADER_CHECKSUM_EN
                chk_at_done = o_checksum;
`endif
            end
            if (o_err) err_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_default();
        for (int i = 0; i < 16; i++) src[i] = DW'((i + 1) * 16000);
    endtask

    // Runs one descriptor; abort>0 raises reset once that many writes seen.
    task automatic run_job(input vec_t v, input int abort, output int acc);
        we_cnt = 0;
        done_cnt = 0;
        err_cnt = 0;
        bad_busy = 0;
        wq_addr.delete();
        foreach (written[a]) written[a] = 1'b0;
        acc = 0;
        i_cfg_base = AW'(v.base);
        i_cfg_len = AW'(v.len);
        i_cfg_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_cfg_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_after_acc = o_checksum;
`endif
        for (int c = 0; c < 40; c++) begin
            i_s_valid = (acc < v.nwords) && (!v.toggle || (c % 2 == 0));
            i_s_data = src[acc % 16];
            @(negedge i_clk);
            #1;
            if (i_s_valid && o_s_ready) acc++;
            if (abort > 0 && we_cnt == abort) begin
                i_rst = 1'b1;
                break;
            end
            if (done_cnt != 0) break;
            @(posedge i_clk);
            #1;
        end
        i_s_valid = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_vec(input vec_t v);
        int acc;
        int mism;
        bit ew;
        logic [DW-1:0] ed;
        run_job(v, 0, acc);
        check({v.name, " err"}, err_cnt, int'(v.exp_err));
        check({v.name, " done"}, done_cnt, int'(!v.exp_err));
        check({v.name, " we_cycles"}, we_cnt, v.exp_we);
        check({v.name, " accepted"}, acc, v.exp_acc);
        check({v.name, " busy_at_done"}, bad_busy, 0);
        check({v.name, " idle_rdy_busy_srdy"},
              int'({o_cfg_ready, o_busy, o_s_ready}), 4);
        if (!v.exp_err) begin
            mism = 0;
            for (int a = 0; a < 1024; a++) begin
                ew = (a == 0) || (a >= v.base && a < v.base + v.len);
                ed = (a == 0) ? 32'h1 : src[(a - v.base) % 16];
                if (written[a] != ew || (ew && img[a] !== ed)) mism++;
            end
            check({v.name, " image"}, mism, 0);
            mism = 0;
            for (int i = 0; i < wq_addr.size(); i++) begin
                if (wq_addr[i] != ((i < v.len) ? v.base + i : 0)) mism++;
            end
            check({v.name, " order"}, mism, 0);
        end
    endtask

    initial begin
        int acc;
        vecs[0] = '{"load",      1,    7, 7, 1'b0, 1'b0, 7, 8};
        vecs[1] = '{"bp",        1,    7, 7, 1'b1, 1'b0, 7, 8};
        vecs[2] = '{"rej_ctrl",  0,    4, 4, 1'b0, 1'b1, 0, 0};
        vecs[3] = '{"rej_len0",  5,    0, 2, 1'b0, 1'b1, 0, 0};
        vecs[4] = '{"rej_wrap",  1021, 4, 4, 1'b0, 1'b1, 0, 0};
        vecs[5] = '{"top_edge",  1020, 4, 4, 1'b0, 1'b0, 4, 5};
        vecs[6] = '{"over_offer", 100, 8, 9, 1'b0, 1'b0, 8, 9};
        fill_default();

        repeat (3) @(posedge i_clk);
        #1;
        check("reset flags", int'({o_cfg_ready, o_s_ready, o_we,
                                   o_busy, o_done, o_err}), 32);
        check("reset addr", int'(o_addr), 0);
        check("reset data", int'(o_data), 0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < 7; i++) check_vec(vecs[i]);

        // Abort after three data writes of a seven word job.
        run_job(vecs[0], 3, acc);
        check("abort flags", int'({o_cfg_ready, o_s_ready, o_we,
                                   o_busy, o_done, o_err}), 32);
        check("abort addr_data", int'(o_addr) + int'(o_data), 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("abort we_cycles", we_cnt, 3);
        check("abort ctrl_untouched", int'(written[0]), 0);
        check("abort done", done_cnt, 0);
        check_vec(vecs[0]);

`ifdef LOADER_CHECKSUM_EN
        src[0] = 32'h1;
        src[1] = 32'h2;
        src[2] = 32'hFFFF_FFFF;
        run_job('{"csum", 10, 3, 3, 1'b0, 1'b0, 3, 4}, 0, acc);
        check("csum at_done", int'(chk_at_done), 2);
        check("csum held", int'(o_checksum), 2);
        fill_default();
        run_job(vecs[0], 0, acc);
        check("csum cleared", int'(chk_after_acc), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
